regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we/write_addr/write_data) between two writeback
//  requesters: the ALU pipeline and the multi-cycle memory-load return path.
//  - Valid/ready handshake on each requester; fixed ALU priority with starvation relief for MEM.
//  - One registered output stage drives RegFile directly.
//  - Writes to x0 are accepted but discarded.
// PARAMETERS
//  DATA_WIDTH    64  width of write data (matches CorePack::data_t)
//  STARVE_LIMIT  3   consecutive denied MEM cycles before MEM takes priority (>=1)
//  CNT_WIDTH     16  width of conflict statistics counter
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           synchronous, active-high reset
//  alu_valid     in   1           ALU writeback request
//  alu_ready     out  1           ALU request granted this cycle (combinational)
//  alu_rd        in   5           ALU destination index (reg_ind_t)
//  alu_data      in   DATA_WIDTH  ALU result
//  mem_valid     in   1           load-return writeback request
//  mem_ready     out  1           MEM request granted this cycle (combinational)
//  mem_rd        in   5           load destination index (reg_ind_t)
//  mem_data      in   DATA_WIDTH  load data
//  rf_we         out  1           RegFile write enable (registered)
//  rf_waddr      out  5           RegFile write address (registered)
//  rf_wdata      out  DATA_WIDTH  RegFile write data (registered)
//  conflict_cnt  out  CNT_WIDTH   cycles with alu_valid & mem_valid both high, wraps
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, state=ALU_FIRST, starve=0.
//  - While rst=1, alu_ready=mem_ready=0; nothing is accepted.
//  - Reset mid-operation drops the pending output stage; no write is issued in the cycle after
//    the reset.
//  Grant (comb, rst=0): at most one of alu_ready/mem_ready high per cycle; ready is never high
//  without the matching valid.
//  - ALU_FIRST: ALU granted if alu_valid, else MEM if mem_valid.
//  - MEM_FIRST: MEM granted if mem_valid, else ALU if alu_valid.
//  - Accept = valid & ready; the requester must hold rd/data stable until accepted.
//  FSM:
//  - ALU_FIRST -> MEM_FIRST when the next starve value equals STARVE_LIMIT.
//  - MEM_FIRST -> ALU_FIRST on a MEM accept.
//  - MEM_FIRST -> ALU_FIRST if mem_valid drops.
//  Starve counter:
//  - +1 each cycle mem_valid & !mem_ready, saturating at STARVE_LIMIT.
//  - Cleared on MEM accept or when mem_valid=0.
//  Output stage: latency exactly 1 cycle from accept to rf_we.
//  - Cycle after an accept: rf_waddr=rd, rf_wdata=data.
//  - rf_we=1 iff rd!=0; an x0 accept still consumes the slot.
//  - No accept in a cycle: rf_we=0; rf_waddr/rf_wdata hold their last values.
//  Back-to-back accepts every cycle are supported; no bubbles are inserted.
//  conflict_cnt: +1 per cycle with alu_valid & mem_valid & !rst; wraps modulo 2^CNT_WIDTH.
//  Same rd from both sources in adjacent cycles: the writes land in grant order (the later
//  grant wins); no merging.
// STRUCTURE
//  CorePack reuse: reg_ind_t, data_t.
//  CorePack additions:
//  - typedef enum logic {WB_ALU_FIRST, WB_MEM_FIRST} wb_arb_state_e.
//  - typedef enum logic {WB_SRC_ALU, WB_SRC_MEM} wb_src_e; the registered stage keeps the
//    source for debug.
//  No sub-module: grant logic, FSM, starve counter and output register sit in one file.
// TESTING
//  1 Reset: assert rst 2 cycles with both valids high -> readys 0, rf_we 0, conflict_cnt 0.
//  2 ALU only: alu_rd=5, alu_data=0xDEAD for 1 cycle -> alu_ready=1; next cycle rf_we=1,
//    rf_waddr=5, rf_wdata=0xDEAD.
//  3 x0 drop: mem_rd=0, mem_data=0x1234 -> mem_ready=1; next cycle rf_we=0.
//  4 Starvation (STARVE_LIMIT=3): alu_valid and mem_valid held high, mem_rd=7 ->
//    - ALU is granted for cycles 0-2; cycle 3 is MEM_FIRST and MEM is granted.
//    - rf_waddr=7 in cycle 4; ALU is granted again in cycle 4; conflict_cnt=5 after 5 cycles.
//  5 Back-to-back: ALU rd=1,2,3 on consecutive cycles -> rf_we high 3 consecutive cycles,
//    addresses 1,2,3 in order.
//  6 Mid-op reset: accept ALU rd=9, assert rst the next cycle -> rf_we=0 in that cycle and
//    the following cycle; FSM=ALU_FIRST.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: register index, data word,
// arbitration state and writeback source.
package regfile_wb_arbiter_pkg;

  localparam int REG_IND_W = 5;
  localparam int DATA_W    = 64;

  typedef logic [REG_IND_W-1:0] reg_ind_t;
  typedef logic [DATA_W-1:0]    data_t;

  typedef enum logic {WB_ALU_FIRST, WB_MEM_FIRST} wb_arb_state_e;
  typedef enum logic {WB_SRC_ALU,   WB_SRC_MEM}   wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU writeback and the
// load-return path: ALU priority with starvation relief for MEM, one registered output stage.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_IND_W-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_IND_W-1:0]  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rf_we,
  output logic [REG_IND_W-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  wb_arb_state_e         state, state_nxt;
  logic [STARVE_W-1:0]   starve, starve_nxt;
  logic                  alu_acc, mem_acc;
  logic                  we_q;
  wb_src_e               rf_src;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      case (state)
        WB_ALU_FIRST: begin
          if (alu_valid)      alu_ready = 1'b1;
          else if (mem_valid) mem_ready = 1'b1;
        end
        WB_MEM_FIRST: begin
          if (mem_valid)      mem_ready = 1'b1;
          else if (alu_valid) alu_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_acc = alu_valid & alu_ready;
  assign mem_acc = mem_valid & mem_ready;

  always_comb begin
    starve_nxt = starve;
    if (!mem_valid || mem_acc)  starve_nxt = '0;
    else if (starve != STARVE_MAX) starve_nxt = starve + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_ALU_FIRST: if (starve_nxt == STARVE_MAX)  state_nxt = WB_MEM_FIRST;
      WB_MEM_FIRST: if (mem_acc || !mem_valid)     state_nxt = WB_ALU_FIRST;
      default:      state_nxt = WB_ALU_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WB_ALU_FIRST;
      starve       <= '0;
      we_q         <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_src       <= WB_SRC_ALU;
      conflict_cnt <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
      if (mem_acc) begin
        we_q     <= (mem_rd != '0);
        rf_waddr <= mem_rd;
        rf_wdata <= mem_data;
        rf_src   <= WB_SRC_MEM;
      end else if (alu_acc) begin
        we_q     <= (alu_rd != '0);
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
        rf_src   <= WB_SRC_ALU;
      end else begin
        we_q <= 1'b0;
      end
      if (alu_valid && mem_valid) conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end

  // A reset arriving while a write sits in the output stage kills that write immediately.
  assign rf_we = we_q & ~rst;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: reset, single grants, x0 drop,
// starvation relief, back-to-back writes and mid-operation reset.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rf_waddr;
  logic [63:0] alu_data, mem_data, rf_wdata;
  logic        rf_we;
  logic [15:0] conflict_cnt;

  int compared = 0;
  int mismatched = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(64), .STARVE_LIMIT(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 2ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h22;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    tick(); tick();
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_alu_ready2", 64'(alu_ready), 64'd0);
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    #1;
    chk("alu_only_ready", 64'(alu_ready), 64'd1);
    chk("alu_only_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("alu_only_we", 64'(rf_we), 64'd1);
    chk("alu_only_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_only_wdata", rf_wdata, 64'hDEAD);

    // x0 write is accepted and discarded
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'h1234;
    #1;
    chk("x0_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_wdata", rf_wdata, 64'h1234);
    chk("x0_cnt", 64'(conflict_cnt), 64'd0);

    // Starvation relief
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hA4;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("starve_alu_ready_c%0d", i), 64'(alu_ready), (i == 3) ? 64'd0 : 64'd1);
      chk($sformatf("starve_mem_ready_c%0d", i), 64'(mem_ready), (i == 3) ? 64'd1 : 64'd0);
      if (i == 4) begin
        chk("starve_mem_waddr", 64'(rf_waddr), 64'd7);
        chk("starve_mem_wdata", rf_wdata, 64'h77);
        chk("starve_mem_we", 64'(rf_we), 64'd1);
      end
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("starve_cnt", 64'(conflict_cnt), 64'd5);
    chk("starve_last_waddr", 64'(rf_waddr), 64'd4);

    // Back-to-back ALU writes
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h101;
    tick();
    alu_rd = 5'd2; alu_data = 64'h102;
    #1;
    chk("b2b_we1", 64'(rf_we), 64'd1);
    chk("b2b_addr1", 64'(rf_waddr), 64'd1);
    tick();
    alu_rd = 5'd3; alu_data = 64'h103;
    #1;
    chk("b2b_we2", 64'(rf_we), 64'd1);
    chk("b2b_addr2", 64'(rf_waddr), 64'd2);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("b2b_we3", 64'(rf_we), 64'd1);
    chk("b2b_addr3", 64'(rf_waddr), 64'd3);
    chk("b2b_data3", rf_wdata, 64'h103);
    tick();
    #1;
    chk("b2b_idle_we", 64'(rf_we), 64'd0);
    chk("b2b_idle_hold", 64'(rf_waddr), 64'd3);

    // Mid-operation reset while in MEM_FIRST with an ALU write pending
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 64'h88;
    tick(); tick(); tick();
    #1;
    chk("midrst_pre_state", 64'(dut.state), 64'(WB_MEM_FIRST));
    chk("midrst_pre_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_we_now", 64'(rf_we), 64'd0);
    chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("midrst_we_next", 64'(rf_we), 64'd0);
    chk("midrst_state", 64'(dut.state), 64'(WB_ALU_FIRST));
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
    chk("midrst_waddr", 64'(rf_waddr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
